// File: rtl/dsp_probe_pkg.sv
// Shared constants, FSM encoding and the saturating magnitude helper for the probe front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dsp_probe_pkg;

  localparam int TSW = 64;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ARMED = 4'b0010;
  localparam logic [3:0] ST_FIRED = 4'b0100;
  localparam logic [3:0] ST_HOLD  = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_FIRED = ST_FIRED,
    S_HOLD  = ST_HOLD
  } state_e;

  // |x| for a dw-bit sample held sign-extended in 32 bits (dw < 32).
  // The most negative code saturates to the largest positive one.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int dw);
    logic [31:0] lim;
    lim = (32'd1 << (dw - 1)) - 32'd1;
    if (x >= 0)
      return $unsigned(x);
    else if (x == -$signed(lim) - 32'sd1)
      return lim;
    else
      return $unsigned(-x);
  endfunction

endpackage

// File: rtl/dsp_probe_frontend_if.sv
// Bundles the DSP-side inputs and ILA-side probe outputs of the probe front end.
// Latency: n/a (wires only).
// Backpressure: none; the ILA samples every cycle.
interface dsp_probe_frontend_if #(
  parameter int NCHAN = 4,
  parameter int DW    = 16,
  parameter int ACCW  = 32,
  parameter int HOW   = 16
);
  logic [NCHAN*DW-1:0]   din;
  logic [NCHAN*ACCW-1:0] acc;
  logic [NCHAN-1:0]      acc_valid;
  logic                  arm;
  logic [NCHAN-1:0]      trig_mask;
  logic [DW-1:0]         trig_thresh;
  logic [HOW-1:0]        holdoff;

  logic [NCHAN*DW-1:0]   probe_din;
  logic [NCHAN*ACCW-1:0] probe_acc;
  logic                  probe_trig;
  logic [3:0]            probe_state;
  logic [63:0]           probe_ts;
  logic [63:0]           probe_evcnt;

  modport master (
    output din, acc, acc_valid, arm, trig_mask, trig_thresh, holdoff,
    input  probe_din, probe_acc, probe_trig, probe_state, probe_ts, probe_evcnt
  );

  modport slave (
    input  din, acc, acc_valid, arm, trig_mask, trig_thresh, holdoff,
    output probe_din, probe_acc, probe_trig, probe_state, probe_ts, probe_evcnt
  );
endinterface

// File: rtl/probe_pipe.sv
// Generic register delay line used to give every probe path the same latency.
// Latency: DEPTH cycles (DEPTH >= 1).
// Backpressure: none; shifts every cycle.
module probe_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift register; stage 0 takes the input, the last stage drives the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_probe_frontend.sv
// Conditions DSP samples/accumulators for the ILA and derives a qualified threshold trigger.
// Latency: PIPE cycles from din/acc to every probe output, trigger aligned with its sample.
// Backpressure: none; free-running, one sample per clk.
module dsp_probe_frontend
  import dsp_probe_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int DW    = 16,   // must be < 32 for abs_sat
  parameter int ACCW  = 32,
  parameter int PIPE  = 2,    // must be >= 2: hit register + FSM register
  parameter int HOW   = 16
) (
  input  logic clk,
  input  logic rstn,
  dsp_probe_frontend_if.slave bus
);

  logic [TSW-1:0]        ts_q;
  logic [NCHAN-1:0]      hit_d, hit_q;
  logic signed [31:0]    din_ext;
  logic [31:0]           thresh_ext;
  logic [NCHAN*ACCW-1:0] acc_hold_q;
  state_e                state_q, state_d;
  logic [3:0]            state_bits;
  logic [HOW-1:0]        hold_q, hold_d;
  logic [TSW-1:0]        evcnt_q, evcnt_d;

  assign thresh_ext = {{(32-DW){1'b0}}, bus.trig_thresh};

  // Free-running timestamp; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ts_q <= '0;
    else       ts_q <= ts_q + 1'b1;
  end

  // Per-channel threshold hit on the saturated magnitude of the incoming sample.
  always_comb begin
    hit_d   = '0;
    din_ext = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      din_ext   = {{(32-DW){bus.din[ch*DW+DW-1]}}, bus.din[ch*DW +: DW]};
      hit_d[ch] = bus.trig_mask[ch] && (abs_sat(din_ext, DW) >= thresh_ext);
    end
  end

  // Stage 1: register the hits so the FSM sees them one cycle after din.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hit_q <= '0;
    else       hit_q <= hit_d;
  end

  // Hold the last strobed accumulator word per channel; this is also the first pipe stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_hold_q <= '0;
    end else begin
      for (int ch = 0; ch < NCHAN; ch++)
        if (bus.acc_valid[ch]) acc_hold_q[ch*ACCW +: ACCW] <= bus.acc[ch*ACCW +: ACCW];
    end
  end

  // FSM, holdoff counter and event counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      evcnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      evcnt_q <= evcnt_d;
    end
  end

  // Trigger decision: disarm beats everything, hits are ignored outside ARMED.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    evcnt_d = evcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!bus.arm)   state_d = S_IDLE;
        else if (|hit_q) state_d = S_FIRED;
      end
      S_FIRED: begin
        if (!bus.arm) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (bus.holdoff == '0) begin
          state_d = S_ARMED;
          hold_d  = '0;
        end else begin
          state_d = S_HOLD;
          hold_d  = bus.holdoff;
        end
      end
      S_HOLD: begin
        if (!bus.arm) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else if (hold_q <= {{(HOW-1){1'b0}}, 1'b1}) begin
          state_d = S_ARMED;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
      end
    endcase
    // Count on the decision so the count is piped alongside the FIRED state.
    if (state_d == S_FIRED && evcnt_q != '1) evcnt_d = evcnt_q + 1'b1;
  end

  assign state_bits = state_d;

  // Alignment: din/ts enter at stage 0, acc after its hold register (stage 1),
  // state/evcnt as next-state from stage 1 -- all emerge PIPE cycles after din.
  probe_pipe #(.W(NCHAN*DW), .DEPTH(PIPE)) u_pipe_din (
    .clk(clk), .rstn(rstn), .d_i(bus.din), .q_o(bus.probe_din)
  );

  probe_pipe #(.W(TSW), .DEPTH(PIPE)) u_pipe_ts (
    .clk(clk), .rstn(rstn), .d_i(ts_q), .q_o(bus.probe_ts)
  );

  probe_pipe #(.W(NCHAN*ACCW), .DEPTH(PIPE-1)) u_pipe_acc (
    .clk(clk), .rstn(rstn), .d_i(acc_hold_q), .q_o(bus.probe_acc)
  );

  probe_pipe #(.W(4), .DEPTH(PIPE-1)) u_pipe_state (
    .clk(clk), .rstn(rstn), .d_i(state_bits), .q_o(bus.probe_state)
  );

  probe_pipe #(.W(TSW), .DEPTH(PIPE-1)) u_pipe_evcnt (
    .clk(clk), .rstn(rstn), .d_i(evcnt_d), .q_o(bus.probe_evcnt)
  );

  assign bus.probe_trig = (bus.probe_state == ST_FIRED);

endmodule

// File: tb/tb_dsp_probe_frontend.sv
// Directed bench for dsp_probe_frontend with hand-computed expectations.
// Latency: checks PIPE=2 alignment of trigger, sample, timestamp and event count.
// Backpressure: n/a.
module tb_dsp_probe_frontend;
  import dsp_probe_pkg::*;

  localparam int NCHAN = 4;
  localparam int DW    = 16;
  localparam int ACCW  = 32;
  localparam int PIPE  = 2;
  localparam int HOW   = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  dsp_probe_frontend_if #(.NCHAN(NCHAN), .DW(DW), .ACCW(ACCW), .HOW(HOW)) bus_if ();

  dsp_probe_frontend #(
    .NCHAN(NCHAN), .DW(DW), .ACCW(ACCW), .PIPE(PIPE), .HOW(HOW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Trigger monitor, sampled on the falling edge.
  int                  cyc           = 0;
  int                  trig_cnt      = 0;
  int                  last_trig_cyc = 0;
  int                  prev_trig_cyc = 0;
  logic [NCHAN*DW-1:0] trig_din      = '0;
  logic [63:0]         trig_ev       = '0;
  logic [63:0]         prev_ev       = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus_if.probe_trig) begin
      prev_trig_cyc = last_trig_cyc;
      last_trig_cyc = cyc;
      prev_ev       = trig_ev;
      trig_ev       = bus_if.probe_evcnt;
      trig_din      = bus_if.probe_din;
      trig_cnt      = trig_cnt + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v);
    bus_if.din[ch*DW +: DW] = v;
  endtask

  task automatic wait_trig(input string tag, input int budget);
    int start;
    int n;
    start = trig_cnt;
    n     = 0;
    while (trig_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, 64'(trig_cnt - start), 64'd1);
  endtask

  // One-cycle sample on a channel; expect a pulse PIPE cycles later or none.
  task automatic pulse_test(input string tag, input int ch, input logic [DW-1:0] v, input int exp_fire);
    int base;
    int c0;
    base = trig_cnt;
    c0   = cyc;
    set_ch(ch, v);
    tick();
    set_ch(ch, '0);
    tick(9);
    check_eq({tag, "_cnt"}, 64'(trig_cnt - base), 64'(exp_fire));
    if (exp_fire != 0) begin
      check_eq({tag, "_lat"}, 64'(last_trig_cyc), 64'(c0 + 3));
      check_eq({tag, "_din"}, 64'(trig_din[ch*DW +: DW]), 64'(v));
    end
  endtask

  initial begin
    int base;
    int c0;
    bus_if.din         = '0;
    bus_if.acc         = '0;
    bus_if.acc_valid   = '0;
    bus_if.arm         = 1'b0;
    bus_if.trig_mask   = '0;
    bus_if.trig_thresh = '0;
    bus_if.holdoff     = '0;
    #1 rstn = 1'b0;
    tick(2);

    // Reset state
    check_eq("rst_din",   64'(bus_if.probe_din), 64'd0);
    check_eq("rst_trig",  64'(bus_if.probe_trig), 64'd0);
    check_eq("rst_state", 64'(bus_if.probe_state), 64'd0);
    check_eq("rst_ts",    bus_if.probe_ts, 64'd0);
    check_eq("rst_ev",    bus_if.probe_evcnt, 64'd0);
    check_eq("rst_acc",   64'(|bus_if.probe_acc), 64'd0);
    rstn = 1'b1;
    tick();
    check_eq("rst_idle", 64'(bus_if.probe_state), 64'(ST_IDLE));

    // T2: basic trigger on ch0
    bus_if.holdoff     = 16'd3;
    bus_if.trig_mask   = 4'b0001;
    bus_if.trig_thresh = 16'd1000;
    bus_if.arm         = 1'b1;
    tick(3);
    check_eq("t2_armed", 64'(bus_if.probe_state), 64'(ST_ARMED));
    pulse_test("t2_999", 0, 16'd999, 0);
    check_eq("t2_ev0", bus_if.probe_evcnt, 64'd0);
    pulse_test("t2_1000", 0, 16'd1000, 1);
    check_eq("t2_ev_at_trig", trig_ev, 64'd1);

    // T3: magnitude saturation on ch2
    bus_if.trig_mask   = 4'b0100;
    bus_if.trig_thresh = 16'd32767;
    pulse_test("t3_neg_min", 2, 16'h8000, 1);
    pulse_test("t3_neg",     2, 16'h8001, 1);
    pulse_test("t3_below",   2, 16'd32766, 0);
    pulse_test("t3_masked",  0, 16'h8000, 0);
    check_eq("t3_ev", bus_if.probe_evcnt, 64'd3);

    // T4: holdoff spacing with a constant hit
    bus_if.holdoff     = 16'd5;
    bus_if.trig_mask   = 4'b0001;
    bus_if.trig_thresh = 16'd1000;
    set_ch(0, 16'd2000);
    wait_trig("t4_a", 20);
    wait_trig("t4_b", 20);
    check_eq("t4_gap5", 64'(last_trig_cyc - prev_trig_cyc), 64'd7);
    check_eq("t4_evinc", trig_ev - prev_ev, 64'd1);
    bus_if.holdoff = 16'd0;
    wait_trig("t4_c", 20);
    wait_trig("t4_d", 20);
    check_eq("t4_gap0", 64'(last_trig_cyc - prev_trig_cyc), 64'd2);
    wait_trig("t4_e", 20);
    check_eq("t4_gap0b", 64'(last_trig_cyc - prev_trig_cyc), 64'd2);

    // T5: disarm during HOLD, then re-arm with the hit already present
    bus_if.holdoff = 16'd5;
    wait_trig("t5_a", 20);
    bus_if.arm = 1'b0;
    tick();
    check_eq("t5_idle", 64'(bus_if.probe_state), 64'(ST_IDLE));
    base = trig_cnt;
    tick(15);
    check_eq("t5_quiet", 64'(trig_cnt - base), 64'd0);
    check_eq("t5_still_idle", 64'(bus_if.probe_state), 64'(ST_IDLE));
    c0 = cyc;
    bus_if.arm = 1'b1;
    wait_trig("t5_rearm", 20);
    check_eq("t5_rearm_lat", 64'(last_trig_cyc), 64'(c0 + 3));

    // Zero threshold: mask=0 never fires, any mask bit fires every ARMED cycle
    bus_if.arm = 1'b0;
    tick();
    bus_if.din         = '0;
    bus_if.holdoff     = 16'd0;
    bus_if.trig_thresh = 16'd0;
    bus_if.trig_mask   = 4'b0000;
    bus_if.arm         = 1'b1;
    base = trig_cnt;
    tick(10);
    check_eq("mask0_never", 64'(trig_cnt - base), 64'd0);
    bus_if.trig_mask = 4'b0001;
    wait_trig("thr0_a", 20);
    wait_trig("thr0_b", 20);
    check_eq("thr0_gap", 64'(last_trig_cyc - prev_trig_cyc), 64'd2);

    // T6: accumulator capture and hold
    bus_if.arm = 1'b0;
    bus_if.acc[ACCW +: ACCW] = 32'hDEADBEEF;
    bus_if.acc_valid = 4'b0010;
    tick();
    bus_if.acc_valid = 4'b0000;
    check_eq("t6_before", 64'(bus_if.probe_acc[ACCW +: ACCW]), 64'd0);
    tick();
    check_eq("t6_capture", 64'(bus_if.probe_acc[ACCW +: ACCW]), 64'hDEADBEEF);
    bus_if.acc[ACCW +: ACCW] = 32'h12345678;
    bus_if.acc[0 +: ACCW]    = 32'hCAFEF00D;
    tick(3);
    check_eq("t6_hold", 64'(bus_if.probe_acc[ACCW +: ACCW]), 64'hDEADBEEF);
    check_eq("t6_ch0", 64'(bus_if.probe_acc[0 +: ACCW]), 64'd0);

    // T1: reset asserted mid-HOLD
    bus_if.holdoff     = 16'd5;
    bus_if.trig_mask   = 4'b0001;
    bus_if.trig_thresh = 16'd1000;
    set_ch(0, 16'd2000);
    bus_if.arm = 1'b1;
    wait_trig("t1_pre", 20);
    tick();
    rstn       = 1'b0;
    bus_if.arm = 1'b0;
    bus_if.din = '0;
    #1;
    check_eq("t1_rst_state", 64'(bus_if.probe_state), 64'd0);
    check_eq("t1_rst_ev",    bus_if.probe_evcnt, 64'd0);
    check_eq("t1_rst_acc",   64'(|bus_if.probe_acc), 64'd0);
    check_eq("t1_rst_ts",    bus_if.probe_ts, 64'd0);
    tick(2);
    rstn = 1'b1;
    tick();
    check_eq("t1_idle", 64'(bus_if.probe_state), 64'(ST_IDLE));
    check_eq("t1_trig", 64'(bus_if.probe_trig), 64'd0);
    tick(2);
    check_eq("t1_ts1", bus_if.probe_ts, 64'd1);
    tick();
    check_eq("t1_ts2", bus_if.probe_ts, 64'd2);
    c0 = cyc;
    set_ch(0, 16'd2000);
    bus_if.arm = 1'b1;
    wait_trig("t1_rearm", 20);
    check_eq("t1_rearm_lat", 64'(last_trig_cyc), 64'(c0 + 3));
    check_eq("t1_ev_restart", trig_ev, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
